ysyx_24100027_lsu: RTL and testbench

YSYX_24100027_LSU -- requirements
Module: ysyx_24100027_lsu

---
 rtl/ysyx_24100027_pkg.sv | 22 ++
 rtl/ysyx_24100027_lsu_align.sv | 63 ++++++
 rtl/ysyx_24100027_lsu.sv | 145 ++++++++++++++
 tb/tb_ysyx_24100027_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100027_pkg.sv
// Shared definitions for the load/store unit.
//   XLEN          : datapath width
//   F3_*          : funct3 access-width codes (b, h, w, bu, hu)
//   lsu_state_e   : LSU control FSM states
package ysyx_24100027_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/ysyx_24100027_lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
//   funct3     : access width code
//   off        : byte offset within the word (addr[1:0])
//   wdata      : raw store data
//   rdata      : raw bus read word
//   wmask      : byte-enable mask for a store of this width/offset
//   wdata_sh   : store data moved onto its byte lanes
//   rdata_ext  : read word shifted down and sign/zero-extended
//   misaligned : access crosses its natural alignment
//   bad_width  : funct3 is not a defined width code
module ysyx_24100027_lsu_align
   import ysyx_24100027_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wmask,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] rdata_ext,
   output logic            misaligned,
   output logic            bad_width
);

   logic [XLEN-1:0] rsh;

   assign wdata_sh = wdata << {off, 3'b000};
   assign rsh      = rdata >> {off, 3'b000};

   always_comb begin
      wmask      = 4'b0000;
      rdata_ext  = '0;
      misaligned = 1'b0;
      bad_width  = 1'b0;
      case (funct3)
         F3_B: begin
            wmask     = 4'b0001 << off;
            rdata_ext = {{24{rsh[7]}}, rsh[7:0]};
         end
         F3_BU: begin
            wmask     = 4'b0001 << off;
            rdata_ext = {24'h0, rsh[7:0]};
         end
         F3_H: begin
            wmask      = 4'b0011 << off;
            misaligned = off[0];
            rdata_ext  = {{16{rsh[15]}}, rsh[15:0]};
         end
         F3_HU: begin
            wmask      = 4'b0011 << off;
            misaligned = off[0];
            rdata_ext  = {16'h0, rsh[15:0]};
         end
         F3_W: begin
            wmask      = 4'b1111;
            misaligned = |off;
            rdata_ext  = rsh;
         end
         default: bad_width = 1'b1;
      endcase
   end

endmodule

// File: rtl/ysyx_24100027_lsu.sv
// Load/store unit: accepts one operation at a time, issues at most one bus
// request, and returns a writeback result with an error flag.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : operation handshake (addr, wdata, ren, wen, funct3)
//   out_valid/out_ready           : writeback handshake (out_data, out_err)
//   mreq_valid/mreq_ready         : bus request (maddr, mwen, mwdata, mwmask)
//   mresp_valid, mresp_rdata      : bus response
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation; decode and latch on in_valid
// REQ   | bus request presented, held until mreq_ready
// WAIT  | awaiting mresp_valid; down-counter bounds the wait
// RESP  | result presented, held until out_ready
module ysyx_24100027_lsu
   import ysyx_24100027_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   input  logic            ren,
   input  logic            wen,
   input  logic [2:0]      funct3,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            out_err,
   output logic            mreq_valid,
   input  logic            mreq_ready,
   output logic [XLEN-1:0] maddr,
   output logic            mwen,
   output logic [XLEN-1:0] mwdata,
   output logic [3:0]      mwmask,
   input  logic            mresp_valid,
   input  logic [XLEN-1:0] mresp_rdata
);

   // Counter holds TIMEOUT-1 .. 0, one value per WAIT cycle.
   localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

   lsu_state_e      state_q, state_d;
   logic [XLEN-1:0] addr_q, wdata_q, res_q;
   logic [2:0]      f3_q;
   logic            wen_q, err_q;
   logic [CW-1:0]   cnt_q;

   logic [2:0]      al_f3;
   logic [1:0]      al_off;
   logic [3:0]      al_wmask;
   logic [XLEN-1:0] al_wdata, al_rdata;
   logic            al_mis, al_bad;
   logic            passthru, op_err, is_idle, st_req;

   // Decode uses live inputs in IDLE so the error path can answer next cycle;
   // afterwards the latched operation drives the aligner.
   assign is_idle = (state_q == ST_IDLE);
   assign al_f3   = is_idle ? funct3    : f3_q;
   assign al_off  = is_idle ? addr[1:0] : addr_q[1:0];

   ysyx_24100027_lsu_align u_align (
      .funct3     (al_f3),
      .off        (al_off),
      .wdata      (wdata_q),
      .rdata      (mresp_rdata),
      .wmask      (al_wmask),
      .wdata_sh   (al_wdata),
      .rdata_ext  (al_rdata),
      .misaligned (al_mis),
      .bad_width  (al_bad)
   );

   assign passthru = ~ren & ~wen;
   assign op_err   = (ren & wen) | ((ren | wen) & (al_bad | al_mis));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = (passthru | op_err) ? ST_RESP : ST_REQ;
         ST_REQ:  if (mreq_ready) state_d = ST_WAIT;
         ST_WAIT: if (mresp_valid || cnt_q == '0) state_d = ST_RESP;
         ST_RESP: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         wen_q   <= 1'b0;
         res_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  f3_q    <= funct3;
                  wen_q   <= wen;
                  err_q   <= op_err;
                  res_q   <= passthru ? addr : '0;
               end
            end
            ST_REQ: begin
               if (mreq_ready) cnt_q <= CNT_LOAD;
            end
            ST_WAIT: begin
               if (mresp_valid) begin
                  res_q <= wen_q ? '0 : al_rdata;
                  err_q <= 1'b0;
               end else if (cnt_q == '0) begin
                  res_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign st_req     = (state_q == ST_REQ);
   assign in_ready   = is_idle;
   assign out_valid  = (state_q == ST_RESP);
   assign out_data   = res_q;
   assign out_err    = err_q;
   assign mreq_valid = st_req;
   assign maddr      = st_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mwen       = st_req & wen_q;
   assign mwdata     = (st_req & wen_q) ? al_wdata : '0;
   assign mwmask     = (st_req & wen_q) ? al_wmask : 4'b0000;

endmodule

// File: tb/tb_ysyx_24100027_lsu.sv
module tb_ysyx_24100027_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] addr = '0, wdata = '0;
   logic        ren = 1'b0, wen = 1'b0;
   logic [2:0]  funct3 = '0;
   logic        out_valid, out_ready = 1'b0, out_err;
   logic [31:0] out_data;
   logic        mreq_valid, mreq_ready = 1'b0, mwen;
   logic [31:0] maddr, mwdata;
   logic [3:0]  mwmask;
   logic        mresp_valid = 1'b0;
   logic [31:0] mresp_rdata = '0;

   int n_chk = 0;
   int n_bad = 0;

   ysyx_24100027_lsu #(.TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .addr(addr), .wdata(wdata), .ren(ren), .wen(wen), .funct3(funct3),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .maddr(maddr),
      .mwen(mwen), .mwdata(mwdata), .mwmask(mwmask),
      .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected behaviour of one operation, from the access rules alone.
   function automatic void ref_model(
      input  logic        r, w,
      input  logic [2:0]  f3,
      input  logic [31:0] a, wd, rd,
      output logic        e_err, e_bus,
      output logic [31:0] e_maddr, e_wdata,
      output logic [3:0]  e_mask,
      output logic [31:0] e_out);
      int size, off;
      logic sgn;
      logic [31:0] v;
      size = 0; sgn = 1'b0;
      case (f3)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 4;
         3'd4: size = 1;
         3'd5: size = 2;
         default: size = 0;
      endcase
      off = int'(a & 32'd3);
      e_err = 1'b0; e_bus = 1'b0; e_maddr = '0; e_wdata = '0; e_mask = '0; e_out = '0;
      if (!r && !w) begin
         e_out = a;
      end else if ((r && w) || size == 0 || (off % size) != 0) begin
         e_err = 1'b1;
      end else begin
         e_bus   = 1'b1;
         e_maddr = a - 32'(off);
         if (w) begin
            e_wdata = wd << (8 * off);
            e_mask  = 4'(((1 << size) - 1) << off);
         end else begin
            v = rd >> (8 * off);
            if (size == 1) begin
               v = v & 32'hFF;
               if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
               v = v & 32'hFFFF;
               if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            e_out = v;
         end
      end
   endfunction

   task automatic sync_idle();
      int n = 0;
      while (!in_ready && n < 400) begin
         out_ready = 1'b1; mreq_ready = 1'b1;
         tick();
         n++;
      end
      out_ready = 1'b0; mreq_ready = 1'b0;
      if (!in_ready) begin
         check_val("sync_idle", in_ready, 1);
         rst = 1'b1; tick(); rst = 1'b0;
      end
   endtask

   task automatic drain_out(input logic [31:0] e_out, input int out_stall);
      for (int i = 0; i < out_stall; i++) begin
         tick();
         check_val("hold_out_valid", out_valid, 1);
         check_val("hold_out_data", out_data, e_out);
         check_val("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check_val("resp_in_ready", in_ready, 0);
      tick();
      out_ready = 1'b0;
      check_val("done_out_valid", out_valid, 0);
      check_val("done_in_ready", in_ready, 1);
   endtask

   task automatic run_op(input logic r, w, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                         input int req_stall, resp_delay, out_stall);
      logic e_err, e_bus;
      logic [31:0] e_maddr, e_wdata, e_out;
      logic [3:0] e_mask;
      ref_model(r, w, f3, a, wd, rd, e_err, e_bus, e_maddr, e_wdata, e_mask, e_out);
      sync_idle();
      in_valid = 1'b1; ren = r; wen = w; funct3 = f3; addr = a; wdata = wd;
      tick();
      in_valid = 1'b0; ren = 1'b0; wen = 1'b0; addr = $urandom; wdata = $urandom;
      check_val("busy_in_ready", in_ready, 0);
      if (!e_bus) begin
         check_val("lat1_out_valid", out_valid, 1);
         check_val("no_mreq", mreq_valid, 0);
      end else begin
         check_val("req_out_valid", out_valid, 0);
         for (int i = 0; i <= req_stall; i++) begin
            if (i > 0) tick();
            check_val("mreq_valid", mreq_valid, 1);
            check_val("maddr", maddr, e_maddr);
            check_val("mwen", mwen, w);
            check_val("mwmask", mwmask, e_mask);
            if (w) check_val("mwdata", mwdata, e_wdata);
            check_val("req_in_ready", in_ready, 0);
         end
         mreq_ready = 1'b1;
         tick();
         mreq_ready = 1'b0;
         check_val("wait_mreq_valid", mreq_valid, 0);
         for (int i = 0; i < resp_delay; i++) begin
            mresp_rdata = $urandom;
            check_val("wait_out_valid", out_valid, 0);
            tick();
         end
         mresp_valid = 1'b1; mresp_rdata = rd;
         tick();
         mresp_valid = 1'b0; mresp_rdata = $urandom;
         check_val("mem_out_valid", out_valid, 1);
      end
      check_val("out_data", out_data, e_out);
      check_val("out_err", out_err, e_err);
      drain_out(e_out, out_stall);
   endtask

   task automatic run_timeout();
      int n = 0;
      sync_idle();
      in_valid = 1'b1; ren = 1'b1; wen = 1'b0; funct3 = 3'b010; addr = 32'h8000_0010;
      tick();
      in_valid = 1'b0; ren = 1'b0;
      check_val("to_mreq_valid", mreq_valid, 1);
      mreq_ready = 1'b1;
      tick();
      mreq_ready = 1'b0;
      while (!out_valid && n < 300) begin
         tick();
         n++;
      end
      check_val("to_wait_cycles", n, 255);
      check_val("to_out_err", out_err, 1);
      check_val("to_out_data", out_data, 0);
      drain_out(32'h0, 0);
   endtask

   task automatic run_reset_in_wait();
      sync_idle();
      in_valid = 1'b1; ren = 1'b1; wen = 1'b0; funct3 = 3'b010; addr = 32'h8000_0020;
      tick();
      in_valid = 1'b0; ren = 1'b0;
      mreq_ready = 1'b1;
      tick();
      mreq_ready = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rstw_in_ready", in_ready, 1);
      check_val("rstw_out_valid", out_valid, 0);
      check_val("rstw_mreq_valid", mreq_valid, 0);
      check_val("rstw_out_data", out_data, 0);
      mresp_valid = 1'b1; mresp_rdata = 32'hDEAD_BEEF;
      tick();
      mresp_valid = 1'b0;
      check_val("stale_out_valid", out_valid, 0);
      check_val("stale_in_ready", in_ready, 1);
      check_val("stale_out_data", out_data, 0);
      tick();
      check_val("stale_out_valid2", out_valid, 0);
   endtask

   initial begin
      logic r, w;
      logic [2:0] f3;
      logic [31:0] a;
      int kind;
      logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_out_err", out_err, 0);
      check_val("rst_mreq_valid", mreq_valid, 0);
      check_val("rst_mwen", mwen, 0);
      check_val("rst_mwdata", mwdata, 0);
      check_val("rst_mwmask", mwmask, 0);
      check_val("rst_maddr", maddr, 0);

      // lb with sign extension from the top byte lane
      run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
      // sh into the upper halfword
      run_op(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'h0000_ABCD, 32'h0, 0, 0, 0);
      // misaligned lw
      run_op(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);
      // pass-through
      run_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0);
      // backpressure on both handshakes
      run_op(1'b1, 1'b0, 3'b010, 32'h8000_0200, 32'h0, 32'hCAFE_F00D, 5, 0, 3);
      // lhu, ren=wen=1, undefined width
      run_op(1'b1, 1'b0, 3'b101, 32'h8000_0302, 32'h0, 32'h8765_4321, 0, 1, 0);
      run_op(1'b1, 1'b1, 3'b010, 32'h8000_0400, 32'h0, 32'h0, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'b011, 32'h8000_0400, 32'h0, 32'h0, 0, 0, 0);

      run_timeout();
      run_reset_in_wait();

      for (int k = 0; k < 60; k++) begin
         kind = int'($urandom_range(0, 9));
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         r = 1'b0; w = 1'b0; f3 = 3'(($urandom_range(0, 7)));
         if (kind == 1) begin
            r = 1'b1; w = 1'b1;
         end else if (kind >= 2 && kind <= 5) begin
            r = 1'b1;
         end else if (kind >= 6) begin
            w = 1'b1;
            f3 = st_f3[$urandom_range(0, 5)];
         end
         run_op(r, w, f3, a, $urandom, $urandom, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
